// File: rtl/pc_seq_pkg.sv
// Shared widths and sequencing op codes for the program-counter sequencer.
package pc_seq_pkg;

  localparam int OP_WIDTH     = 3;
  localparam int OFFSET_WIDTH = 12;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NEXT  = 3'd0,
    OP_SKIP  = 3'd1,
    OP_RJMP  = 3'd2,
    OP_JMP   = 3'd3,
    OP_CALL  = 3'd4,
    OP_RCALL = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  // True for ops that redirect the fetch stream away from pc+1 / pc+2.
  function automatic logic is_nonseq(op_e op);
    return (op == OP_RJMP) || (op == OP_JMP) || (op == OP_CALL) ||
           (op == OP_RCALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Decoder <-> sequencer bundle: op/operands in, fetch address and status out.
interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int STACK_DEPTH = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                    stall;
  logic [OP_WIDTH-1:0]     op;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0]     target;
  logic [PC_WIDTH-1:0]     pc;
  logic                    flush;
  logic [DEPTH_W-1:0]      depth;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output stall, op, offset, target,
    input  pc, flush, depth, overflow, underflow
  );

  modport slave (
    input  stall, op, offset, target,
    output pc, flush, depth, overflow, underflow
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Circular LIFO return stack; a push when full overwrites the oldest entry.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int STACK_DEPTH = 4,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1),
  localparam int PTR_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] pop_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_W-1:0]  depth
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(STACK_DEPTH - 1);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr_inc;
  logic [DEPTH_W-1:0]  count;

  assign rd_ptr     = (wr_ptr == '0) ? LAST : wr_ptr - PTR_W'(1);
  assign wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
  assign pop_data   = mem[rd_ptr];
  assign full       = (count == DEPTH_W'(STACK_DEPTH));
  assign empty      = (count == '0);
  assign depth      = count;

  // Pointer and occupancy; count saturates at full, pop on empty is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (!full) count <= count + DEPTH_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= rd_ptr;
      count  <= count - DEPTH_W'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: next-pc mux, flush and sticky stack flags.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 12,
  parameter int                  STACK_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic        clk,
  input logic        reset,
  pc_seq_if.slave    bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  op_e                 op;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_rel;
  logic [PC_WIDTH-1:0] off_ext;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pop_data;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                flush_q;
  logic                ovf_q;
  logic                unf_q;
  logic [DEPTH_W-1:0]  depth;

  assign op      = op_e'(bus.op);
  // Signed size cast sign-extends for wide pcs and truncates for narrow ones.
  assign off_ext = PC_WIDTH'($signed(bus.offset));
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign pc_rel  = pc_inc + off_ext;

  pc_ret_stack #(
    .PC_WIDTH   (PC_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .pop_data (pop_data),
    .full     (full),
    .empty    (empty),
    .depth    (depth)
  );

  // Next fetch address and stack requests from the decoded op; stall freezes the stack.
  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_SKIP:  pc_next = pc_q + PC_WIDTH'(2);
      OP_RJMP:  pc_next = pc_rel;
      OP_JMP:   pc_next = bus.target;
      OP_CALL: begin
        pc_next = bus.target;
        push    = !bus.stall;
      end
      OP_RCALL: begin
        pc_next = pc_rel;
        push    = !bus.stall;
      end
      OP_RET: begin
        pc_next = empty ? RESET_VECTOR : pop_data;
        pop     = !bus.stall;
      end
      default:  pc_next = pc_inc;
    endcase
  end

  // Registered pc, flush and sticky flags; everything holds while stalled except flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.stall) begin
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_next;
      flush_q <= is_nonseq(op);
      ovf_q   <= ovf_q | (push & full);
      unf_q   <= unf_q | (pop & empty);
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flush     = flush_q;
  assign bus.depth     = depth;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule
